// File: rtl/encode_sched_pkg.sv
// rtl/encode_sched_pkg.sv - shared types and constants for the encode scheduler
package encode_sched_pkg;

    localparam int N_REQ = 2;
    localparam int REQ0  = 0;
    localparam int REQ1  = 1;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_START,
        ST_WAIT,
        ST_READ
    } state_e;

endpackage

// File: rtl/rr_arb2.sv
// rtl/rr_arb2.sv - two-input round-robin arbiter; favours the requester not served last
module rr_arb2
    import encode_sched_pkg::*;
(
    input  logic [N_REQ-1:0] req_i,
    input  logic             last_i,
    output logic [N_REQ-1:0] gnt_o
);

    always_comb begin
        gnt_o = req_i;
        if (req_i == 2'b11) begin
            gnt_o = last_i ? 2'b01 : 2'b10;
        end
    end

endmodule

// File: rtl/encode_sched.sv
// rtl/encode_sched.sv - shares one encode_wrapper between two requesters
// Optional WAIT watchdog enabled by defining ENC_SCHED_TIMEOUT_EN.
module encode_sched
    import encode_sched_pkg::*;
#(
    parameter int RP_D_SIZE   = 13,
    parameter int RP_DEPTH    = 10,
    parameter int OUT_D_SIZE  = 8,
    parameter int OUT_DEPTH   = 11,
    parameter int TIMEOUT_CYC = 65535
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [N_REQ-1:0]            req,
    input  logic [N_REQ-1:0]            req_mode,
    input  logic [N_REQ-1:0]            ld_done,
    input  logic [N_REQ-1:0]            rel,
    input  logic [N_REQ-1:0]            rq_we,
    input  logic [N_REQ*RP_DEPTH-1:0]   rq_aw,
    input  logic [N_REQ*RP_D_SIZE-1:0]  rq_dw,
    input  logic [N_REQ*OUT_DEPTH-1:0]  rq_ar,
    output logic [N_REQ-1:0]            gnt,
    output logic [N_REQ-1:0]            rdy,
    output logic [OUT_D_SIZE-1:0]       cd_dr_o,
    output logic                        busy,
    output logic                        err,
    output logic                        enc_start,
    output logic                        enc_mode,
    input  logic                        enc_done,
    output logic                        rp_we,
    output logic [RP_DEPTH-1:0]         rp_aw,
    output logic [RP_D_SIZE-1:0]        rp_dw,
    output logic [OUT_DEPTH-1:0]        cd_ar,
    input  logic [OUT_D_SIZE-1:0]       cd_dr
);

    state_e           state_q, state_d;
    logic [N_REQ-1:0] gnt_q, gnt_d, arb_gnt;
    logic             mode_q, mode_d;
    logic             ptr_q, ptr_d;
    logic             owner;
    logic             timeout;

    assign owner = gnt_q[REQ1];

    rr_arb2 u_arb (
        .req_i  (req),
        .last_i (ptr_q),
        .gnt_o  (arb_gnt)
    );

`ifdef ENC_SCHED_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);
    logic [CNT_W-1:0] wcnt_q, wcnt_d;

    // Counts WAIT cycles; sits at zero in every other state so it restarts on entry.
    assign wcnt_d  = (state_q == ST_WAIT) ? wcnt_q + CNT_W'(1) : '0;
    assign timeout = (state_q == ST_WAIT) && !enc_done && (wcnt_q == CNT_W'(TIMEOUT_CYC));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wcnt_q <= '0;
        end else begin
            wcnt_q <= wcnt_d;
        end
    end
`else
    logic unused_timeout_cyc;
    assign unused_timeout_cyc = ^TIMEOUT_CYC;
    assign timeout            = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            gnt_q   <= '0;
            mode_q  <= 1'b0;
            ptr_q   <= 1'b1;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            mode_q  <= mode_d;
            ptr_q   <= ptr_d;
        end
    end

    always_comb begin
        state_d = state_q;
        gnt_d   = gnt_q;
        mode_d  = mode_q;
        ptr_d   = ptr_q;
        unique case (state_q)
            ST_IDLE: begin
                gnt_d  = '0;
                mode_d = 1'b0;
                if (|req) begin
                    gnt_d   = arb_gnt;
                    mode_d  = req_mode[arb_gnt[REQ1]];
                    state_d = ST_LOAD;
                end
            end
            ST_LOAD: begin
                // Dropping the request beats a same-cycle ld_done: no start is issued.
                if (!req[owner]) begin
                    gnt_d   = '0;
                    mode_d  = 1'b0;
                    state_d = ST_IDLE;
                end else if (ld_done[owner]) begin
                    state_d = ST_START;
                end
            end
            ST_START: state_d = ST_WAIT;
            ST_WAIT: begin
                if (enc_done) begin
                    state_d = ST_READ;
                end else if (timeout) begin
                    gnt_d   = '0;
                    mode_d  = 1'b0;
                    ptr_d   = owner;
                    state_d = ST_IDLE;
                end
            end
            ST_READ: begin
                if (rel[owner]) begin
                    gnt_d   = '0;
                    mode_d  = 1'b0;
                    ptr_d   = owner;
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        gnt       = gnt_q;
        enc_mode  = mode_q;
        busy      = (state_q != ST_IDLE);
        enc_start = (state_q == ST_START);
        err       = timeout;
        rdy       = '0;
        rp_we     = 1'b0;
        rp_aw     = '0;
        rp_dw     = '0;
        cd_ar     = '0;
        if (state_q == ST_LOAD) begin
            rp_we = rq_we[owner];
            rp_aw = owner ? rq_aw[REQ1*RP_DEPTH +: RP_DEPTH]   : rq_aw[REQ0*RP_DEPTH +: RP_DEPTH];
            rp_dw = owner ? rq_dw[REQ1*RP_D_SIZE +: RP_D_SIZE] : rq_dw[REQ0*RP_D_SIZE +: RP_D_SIZE];
        end
        if (state_q == ST_READ) begin
            rdy   = gnt_q;
            cd_ar = owner ? rq_ar[REQ1*OUT_DEPTH +: OUT_DEPTH] : rq_ar[REQ0*OUT_DEPTH +: OUT_DEPTH];
        end
    end

    assign cd_dr_o = cd_dr;

endmodule

// File: tb/tb_encode_sched.sv
// tb/tb_encode_sched.sv - randomized scoreboard bench for encode_sched (timeout case with ENC_SCHED_TIMEOUT_EN)
module tb_encode_sched;
    localparam int RP_D_SIZE   = 13;
    localparam int RP_DEPTH    = 10;
    localparam int OUT_D_SIZE  = 8;
    localparam int OUT_DEPTH   = 11;
    localparam int TIMEOUT_CYC = 100;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic [1:0] req = '0, req_mode = '0, ld_done = '0, rel = '0, rq_we = '0;
    logic [2*RP_DEPTH-1:0]  rq_aw = '0;
    logic [2*RP_D_SIZE-1:0] rq_dw = '0;
    logic [2*OUT_DEPTH-1:0] rq_ar = '0;
    logic [1:0] gnt, rdy;
    logic [OUT_D_SIZE-1:0] cd_dr_o;
    logic busy, err, enc_start, enc_mode, rp_we;
    logic enc_done = 1'b0;
    logic [RP_DEPTH-1:0]   rp_aw;
    logic [RP_D_SIZE-1:0]  rp_dw;
    logic [OUT_DEPTH-1:0]  cd_ar;
    logic [OUT_D_SIZE-1:0] cd_dr = '0;

    always #5 clk = ~clk;

    encode_sched #(
        .RP_D_SIZE(RP_D_SIZE), .RP_DEPTH(RP_DEPTH), .OUT_D_SIZE(OUT_D_SIZE),
        .OUT_DEPTH(OUT_DEPTH), .TIMEOUT_CYC(TIMEOUT_CYC)
    ) dut (
        .clk(clk), .rst_n(rst_n), .req(req), .req_mode(req_mode), .ld_done(ld_done),
        .rel(rel), .rq_we(rq_we), .rq_aw(rq_aw), .rq_dw(rq_dw), .rq_ar(rq_ar),
        .gnt(gnt), .rdy(rdy), .cd_dr_o(cd_dr_o), .busy(busy), .err(err),
        .enc_start(enc_start), .enc_mode(enc_mode), .enc_done(enc_done),
        .rp_we(rp_we), .rp_aw(rp_aw), .rp_dw(rp_dw), .cd_ar(cd_ar), .cd_dr(cd_dr)
    );

    // Arbitrary deterministic code byte produced by the stand-in encoder.
    function automatic logic [7:0] enc_fn(input logic [12:0] c, input logic m, input logic hi);
        return m ? (c[7:0] ^ {hi, 7'h00}) : (c[12:5] + {7'h00, hi});
    endfunction

    // Stand-in encode_wrapper: coefficient RAM, code RAM, fixed 50-cycle encode.
    logic [12:0] rp_ram [1024];
    logic [7:0]  cd_ram [2048];
    int   enc_cnt = 0;
    logic stub_mode = 1'b0;
    bit   stub_hold = 1'b0;

    always @(posedge clk) begin
        enc_done <= 1'b0;
        cd_dr    <= cd_ram[cd_ar];
        if (rp_we) rp_ram[rp_aw] <= rp_dw;
        if (enc_start) begin
            enc_cnt   <= 50;
            stub_mode <= enc_mode;
        end else if (enc_cnt > 0) begin
            enc_cnt <= enc_cnt - 1;
            if (enc_cnt == 1 && !stub_hold) begin
                enc_done <= 1'b1;
                for (int a = 0; a < 2048; a++) cd_ram[a] <= enc_fn(rp_ram[a % 1024], stub_mode, a >= 1024);
            end
        end
    end

    int n_chk = 0, n_fail = 0;
    logic [12:0] model_mem [1024];
    bit   last_srv = 1'b1;
    logic cur_mode = 1'b0;
    bit   rd_chk = 1'b0;

    logic [1:0] q_gnt[$];
    logic       q_start[$];
    logic [1:0] q_rdy[$];
    logic [7:0] q_rd[$];
    int         q_err[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h required %0h", name, act, exp);
        end
    endtask

    task automatic fail_evt(input string name);
        n_chk++;
        n_fail++;
        $display("FAIL %s: event seen/missing where none was required", name);
    endtask

    // Monitor: pops scoreboard entries whenever the DUT presents an event.
    logic [1:0] gnt_prev = '0, rdy_prev = '0;
    logic start_prev = 1'b0;
    int cyc = 0, start_cyc = 0;
    always @(negedge clk) begin
        cyc++;
        if (gnt != 2'b00 && gnt_prev == 2'b00) begin
            if (q_gnt.size() == 0) fail_evt("unexpected_gnt");
            else chk("gnt", gnt, q_gnt.pop_front());
        end
        if (enc_start) begin
            if (start_prev) fail_evt("enc_start_width");
            if (q_start.size() == 0) fail_evt("unexpected_enc_start");
            else chk("enc_mode_at_start", enc_mode, q_start.pop_front());
            start_cyc = cyc;
        end
        if (rdy != 2'b00 && rdy_prev == 2'b00) begin
            if (q_rdy.size() == 0) fail_evt("unexpected_rdy");
            else begin
                chk("rdy", rdy, q_rdy.pop_front());
                chk("enc_mode_at_rdy", enc_mode, cur_mode);
            end
        end
        if (err) begin
            if (q_err.size() == 0) fail_evt("unexpected_err");
            else chk("err_delay", cyc - start_cyc, q_err.pop_front());
        end
        if (rd_chk) begin
            if (q_rd.size() == 0) fail_evt("unexpected_read");
            else chk("cd_dr_o", cd_dr_o, q_rd.pop_front());
        end
        gnt_prev   = gnt;
        rdy_prev   = rdy;
        start_prev = enc_start;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [1:0] model_pick(input logic [1:0] r);
        if (r == 2'b11) return last_srv ? 2'b01 : 2'b10;
        return r;
    endfunction

    // kind: 0 full job, 1 abort in LOAD, 2 reset in WAIT, 3 watchdog expiry
    task automatic run_job(input logic [1:0] rq, input logic [1:0] modes, input int nwr,
                           input int nrd, input bit intr, input bit keep, input int kind);
        logic [1:0] g;
        int o, no, n, a;
        logic [12:0] d;
        logic om;
        g  = model_pick(rq);
        o  = g[1] ? 1 : 0;
        no = 1 - o;
        om = modes[o];
        q_gnt.push_back(g);
        req = rq;
        req_mode = modes;
        n = 0;
        while (gnt == 2'b00 && n < 10) begin tick(); n++; end
        chk("gnt_latency", n, 1);
        for (int i = 0; i < nwr; i++) begin
            a = (i == 0 && !intr) ? 3 : $urandom_range(0, 1023);
            if (intr && a == 3) a = 4;
            d = 13'($urandom);
            rq_we = '0;
            rq_we[o] = 1'b1;
            rq_aw[o*RP_DEPTH +: RP_DEPTH]   = 10'(a);
            rq_dw[o*RP_D_SIZE +: RP_D_SIZE] = d;
            model_mem[a] = d;
            rq_we[no] = intr ? 1'b1 : 1'($urandom);
            rq_aw[no*RP_DEPTH +: RP_DEPTH]   = intr ? 10'd3 : 10'($urandom);
            rq_dw[no*RP_D_SIZE +: RP_D_SIZE] = intr ? 13'h1ABC : 13'($urandom);
            tick();
        end
        rq_we = '0;
        if (kind == 1) begin
            req[o] = 1'b0;
            ld_done[o] = 1'b1;
            tick();
            ld_done = '0;
            chk("abort_gnt", gnt, 0);
            chk("abort_busy", busy, 0);
            req = '0;
            return;
        end
        ld_done[o] = 1'b1;
        q_start.push_back(om);
        cur_mode = om;
        tick();
        ld_done = '0;
        ld_done[no] = 1'b1;
        rel = 2'b11;
        tick();
        ld_done = '0;
        rel = '0;
        if (kind == 2) begin
            repeat (3) tick();
            rst_n = 1'b0;
            req = '0;
            tick();
            chk("rst_gnt", gnt, 0);
            chk("rst_busy_rdy_err", {busy, rdy, err}, 0);
            chk("rst_start_mode", {enc_start, enc_mode}, 0);
            chk("rst_wport", {rp_we, rp_aw, rp_dw}, 0);
            chk("rst_cd_ar", cd_ar, 0);
            rst_n = 1'b1;
            last_srv = 1'b1;
            repeat (70) tick();
            chk("post_rst_rdy", rdy, 0);
            chk("post_rst_busy", busy, 0);
            return;
        end
        if (kind == 3) begin
            q_err.push_back(TIMEOUT_CYC + 1);
            n = 0;
            while (busy && n < 400) begin tick(); n++; end
            if (busy) fail_evt("timeout_never_idle");
            chk("timeout_gnt", gnt, 0);
            last_srv = o[0];
            req = '0;
            return;
        end
        q_rdy.push_back(g);
        n = 0;
        while (rdy == 2'b00 && n < 200) begin tick(); n++; end
        if (rdy == 2'b00) fail_evt("rdy_timeout");
        for (int i = 0; i < nrd; i++) begin
            a = (i == 0) ? 5 : (i == 1) ? 3 : $urandom_range(0, 2047);
            rq_ar[o*OUT_DEPTH +: OUT_DEPTH]  = 11'(a);
            rq_ar[no*OUT_DEPTH +: OUT_DEPTH] = 11'($urandom);
            q_rd.push_back(enc_fn(model_mem[a % 1024], om, a >= 1024));
            tick();
            rd_chk = 1'b1;
            tick();
            rd_chk = 1'b0;
        end
        rel[o] = 1'b1;
        if (!keep) req = '0;
        tick();
        rel = '0;
        last_srv = o[0];
        chk("rel_gnt", gnt, 0);
        chk("rel_rdy", rdy, 0);
    endtask

    initial begin
        for (int i = 0; i < 1024; i++) begin rp_ram[i] = '0; model_mem[i] = '0; end
        for (int i = 0; i < 2048; i++) cd_ram[i] = '0;
        repeat (3) tick();
        chk("reset_gnt_rdy", {gnt, rdy}, 0);
        chk("reset_busy_err", {busy, err}, 0);
        chk("reset_start_mode", {enc_start, enc_mode}, 0);
        chk("reset_wport", {rp_we, rp_aw, rp_dw}, 0);
        chk("reset_cd_ar", cd_ar, 0);
        rst_n = 1'b1;
        tick();

        run_job(2'b01, 2'b01, 761, 4, 1'b0, 1'b0, 0);

        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        last_srv = 1'b1;
        run_job(2'b11, 2'($urandom), 20, 3, 1'b0, 1'b1, 0);
        run_job(2'b11, 2'($urandom), 20, 3, 1'b0, 1'b1, 0);
        run_job(2'b11, 2'($urandom), 20, 3, 1'b0, 1'b0, 0);

        run_job(2'b01, 2'b00, 30, 3, 1'b1, 1'b0, 0);
        run_job(2'b10, 2'b10, 30, 3, 1'b1, 1'b0, 0);

        run_job(2'b01, 2'b01, 5, 0, 1'b0, 1'b0, 1);
        run_job(2'b10, 2'b10, 5, 0, 1'b0, 1'b0, 2);
`ifdef ENC_SCHED_TIMEOUT_EN
        stub_hold = 1'b1;
        run_job(2'b01, 2'b01, 5, 0, 1'b0, 1'b0, 3);
        stub_hold = 1'b0;
        repeat (60) tick();
`endif
        repeat (8) begin
            run_job(2'($urandom_range(1, 3)), 2'($urandom), $urandom_range(1, 40), 4,
                    1'($urandom), 1'b0, 0);
        end

        repeat (5) tick();
        chk("drain_gnt", q_gnt.size(), 0);
        chk("drain_start", q_start.size(), 0);
        chk("drain_rdy", q_rdy.size(), 0);
        chk("drain_rd", q_rd.size(), 0);
        chk("drain_err", q_err.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL global_timeout: simulation did not finish, required completion");
        $fatal(1, "global timeout");
    end

endmodule

// File: doc/encode_sched.md
# encode_sched

Round-robin scheduler that shares one `encode_wrapper` instance (encoder, input RAM, output RAM) between two requesters. Each requester owns the encoder for one whole job: load the coefficient RAM, run the encode, read back the code bytes. The scheduler sequences `start`/`mode`, multiplexes the RAM write and read ports, and signals completion. It sits between the key-gen/encap datapaths and the encode wrapper.

## Interface
- `RP_D_SIZE`, 13, coefficient width
- `RP_DEPTH`, 10, coefficient address width
- `OUT_D_SIZE`, 8, code byte width
- `OUT_DEPTH`, 11, code address width
- `TIMEOUT_CYC`, 65535, watchdog limit in cycles; used only with `ENC_SCHED_TIMEOUT_EN`
- `clk`  in  1  clock
- `rst_n`  in  1  synchronous, active-low reset
- `req`  in  2  per-requester job request (level)
- `req_mode`  in  2  per-requester mode: 1 = Rq encode, 0 = rounded encode
- `ld_done`  in  2  per-requester one-cycle pulse: RAM load finished
- `rel`  in  2  per-requester one-cycle pulse: readback finished
- `rq_we`  in  2  per-requester RAM write enable
- `rq_aw`  in  2×RP_DEPTH  per-requester write address (requester i in slice i)
- `rq_dw`  in  2×RP_D_SIZE  per-requester write data
- `rq_ar`  in  2×OUT_DEPTH  per-requester code read address
- `gnt`  out  2  one-hot ownership
- `rdy`  out  2  owner's code RAM valid, level
- `cd_dr_o`  out  OUT_D_SIZE  code data broadcast (`cd_dr` passthrough)
- `busy`  out  1  state ≠ IDLE
- `err`  out  1  watchdog expiry pulse
- `enc_start`  out  1  to wrapper `start`
- `enc_mode`  out  1  to wrapper `mode`
- `enc_done`  in  1  from wrapper `done`
- `rp_we`, `rp_aw`, `rp_dw`  out  1/RP_DEPTH/RP_D_SIZE  to wrapper write port
- `cd_ar`  out  OUT_DEPTH  to wrapper read address
- `cd_dr`  in  OUT_D_SIZE  from wrapper read data

## Operation
- States: IDLE → LOAD → START → WAIT → READ → IDLE.
- IDLE: if any `req` is high, the arbiter picks owner `o`. Register `gnt[o]` and `enc_mode <= req_mode[o]`, then go to LOAD. If both request, pick the requester not served last. After reset, requester 0 has priority.
- LOAD: `rp_we/aw/dw` follow owner slice. Non-owner `rq_we` is ignored.
  - `ld_done[o]` → START.
  - `req[o]` low → abort to IDLE. `gnt` clears and no start is issued. Abort wins over a simultaneous `ld_done`.
- START: `enc_start` high for exactly one cycle → WAIT.
- WAIT: first cycle with `enc_done` high → READ. `rp_we` is forced 0 from START onward.
- READ: `rdy[o]` = 1 and `cd_ar` = owner `rq_ar` slice.
  - `rel[o]` → IDLE. Clear `gnt`/`rdy`; last-served pointer becomes `o`.
  - `req` changes in WAIT/READ are ignored.
- `enc_mode` is stable from grant until return to IDLE. Outside READ, `cd_ar` = 0.
- `enc_done`, `ld_done`, and `rel` are ignored outside their own states. Pulses from non-owners are always ignored.

## Timing
- Reset values: state IDLE, all outputs 0 (`gnt`, `rdy`, `busy`, `err`, `enc_start`, `enc_mode`, `rp_we`, `rp_aw`, `rp_dw`, `cd_ar`), pointer = 1 (requester 0 favoured).
- `req` at cycle t → `gnt` at t+1.
- `ld_done` at t → `enc_start` at t+1 → WAIT at t+2.
- `enc_done` at t → `rdy` at t+1.
- `rel` at t → `gnt`/`rdy` low at t+1. A new grant is possible at t+2.
- Write and read muxes are combinational from registered state/owner. No added latency.
- `cd_dr_o` = `cd_dr`: data returns one cycle after `rq_ar` (RAM read latency).
- Reset mid-job returns to IDLE in one cycle. The wrapper has no reset, so a stray `enc_done` in IDLE is ignored.

## Configuration
- `ENC_SCHED_TIMEOUT_EN` defined:
  - A WAIT-cycle counter of width clog2(TIMEOUT_CYC+1) clears on WAIT entry.
  - If the counter reaches `TIMEOUT_CYC` with no `enc_done`: `err` pulses one cycle, `gnt` clears, `rdy` stays 0, the pointer updates, and the state returns to IDLE.
- Not defined: no counter; WAIT is unbounded and `err` is tied 0.

## Structure
- Package `encode_sched_pkg` holds:
  - the state enum (IDLE, LOAD, START, WAIT, READ)
  - `N_REQ = 2`
  - slice-index helper constants
- Sub-module `rr_arb2`: two-input round-robin arbiter. Inputs: `req[1:0]`, last-served pointer. Output: one-hot winner.
- Mux and FSM logic live in `encode_sched`.

## Test plan
- Single job: req=01, mode=1, 761 writes, `ld_done`; model `enc_done` 50 cycles after start → one `enc_start` pulse, `enc_mode`=1 throughout, `rdy`=01; read addr 5 returns RAM byte, `rel` → idle.
- Contention: req=11 after reset → grant 01 first. Hold req=11; after `rel` → grant 10, then 01 again.
- Isolation: during req 0's LOAD, requester 1 drives `rq_we`=1, addr 3, data 0x1ABC → RAM addr 3 unchanged; owner writes land.
- Abort: drop `req[0]` in LOAD with a simultaneous `ld_done` → no `enc_start`, `gnt`=00 next cycle.
- Reset in WAIT: `rst_n`=0 for one cycle → all outputs 0; a later `enc_done` in IDLE → no `rdy`.
- Timeout (macro on, `TIMEOUT_CYC`=100): withhold `enc_done` → `err` single pulse 100 cycles after WAIT entry, idle, `rdy` never high.
